// File: rtl/svc_soc_uart_pkg.sv
// Shared types and helpers for the SoC UART blocks.
// Receive FSM states and bit-period computation.
package svc_soc_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    function automatic int clks_per_bit(
        input int clock_freq,
        input int baud_rate
    );
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/svc_soc_uart_rx_if.sv
// Read-side handshake between the UART RX FIFO and the register bank.
// master = UART receiver, slave = consumer popping bytes.
interface svc_soc_uart_rx_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                         rd_valid;
    logic [7:0]                   rd_data;
    logic                         rd_ready;
    logic [$clog2(FIFO_DEPTH):0]  count;

    modport master (
        output rd_valid,
        output rd_data,
        output count,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  count,
        output rd_ready
    );
endinterface

// File: rtl/svc_soc_uart_rx_fifo.sv
// First-word-fall-through byte FIFO for the UART receiver.
// Pointers carry one extra wrap bit to tell full from empty.
module svc_soc_uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [7:0]             head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = wr_ptr - rd_ptr;
    assign head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // Advance pointers on accepted push/pop; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/svc_soc_uart_rx.sv
// UART 8N1 receiver: synchronizer, sampling FSM, error flags
// and a FWFT byte FIFO read through the register bank.
module svc_soc_uart_rx
    import svc_soc_uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                urx_pin,
    input  logic                clr_err,
    output logic                overrun,
    output logic                frame_err,
    svc_soc_uart_rx_if.master   rd
);
    localparam int CPB = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    uart_rx_state_t state, state_n;
    logic [CW-1:0]  bit_cnt, cnt_n;
    logic [2:0]     idx, idx_n;
    logic [7:0]     shreg, sh_n;
    logic           sync1, rx_s;
    logic           push_req, ferr_set, ovr_set;
    logic           pop, full, empty;

    // Two-flop synchronizer; idle-high reset avoids a false start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= urx_pin;
            rx_s  <= sync1;
        end
    end

    // FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            idx     <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
            idx     <= idx_n;
            shreg   <= sh_n;
        end
    end

    // Next-state: mid-bit start check, then full-bit data/stop samples.
    always_comb begin
        state_n  = state;
        cnt_n    = bit_cnt + 1'b1;
        idx_n    = idx;
        sh_n     = shreg;
        push_req = 1'b0;
        ferr_set = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (bit_cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_cnt == LAST) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, shreg[7:1]};
                    idx_n = idx + 1'b1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (bit_cnt == LAST) begin
                    cnt_n    = '0;
                    state_n  = IDLE;
                    push_req = rx_s;
                    ferr_set = !rx_s;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign pop     = rd.rd_valid && rd.rd_ready;
    assign ovr_set = push_req && full && !pop;
    assign rd.rd_valid = !empty;

    // Sticky error flags; a new event beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovr_set)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (ferr_set)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

    svc_soc_uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_req),
        .push_data(sh_n),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (rd.rd_data),
        .count    (rd.count)
    );
endmodule

// File: tb/tb_svc_soc_uart_rx.sv
// Randomized scoreboard bench for the UART receiver.
// Frames are bit-banged at 16 clocks per bit.
module tb_svc_soc_uart_rx;
    localparam int CPB   = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pin = 1'b1;
    logic clr = 1'b0;
    logic rdy = 1'b0;
    logic ovr;
    logic ferr;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    bit         exp_ovr = 1'b0;
    bit         exp_ferr = 1'b0;
    bit         rnd_on = 1'b0;

    svc_soc_uart_rx_if #(.FIFO_DEPTH(DEPTH)) rif ();
    assign rif.rd_ready = rdy;

    svc_soc_uart_rx #(
        .CLOCK_FREQ(1_843_200),
        .BAUD_RATE (115_200),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .urx_pin  (pin),
        .clr_err  (clr),
        .overrun  (ovr),
        .frame_err(ferr),
        .rd       (rif.master)
    );

    always #5 clk = ~clk;

    // Monitor: every DUT pop must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rif.rd_valid && rif.rd_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_extra: got %02h, expected no byte",
                         rif.rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rif.rd_data !== mon_exp) begin
                    miscompares++;
                    $display("FAIL pop_data: got %02h, expected %02h",
                             rif.rd_data, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame; the model records the byte when the stop
    // bit has been sampled. Optionally pops in that same cycle.
    task automatic send(input logic [7:0] b,
                        input bit stop_ok,
                        input bit pop_pulse);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k == 155) begin
                if (!stop_ok) exp_ferr = 1'b1;
                else if (exp_q.size() < DEPTH) exp_q.push_back(b);
                else exp_ovr = 1'b1;
            end
            pin = bits[k / CPB];
            if (!stop_ok && k >= 156) pin = 1'b1;
            if (pop_pulse) rdy = (k == 154);
            tick(1);
        end
        pin = 1'b1;
        tick(4);
    endtask

    task automatic drain();
        rdy = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 8; i++) begin
            tick(1);
            if (exp_q.size() == 0) break;
        end
        rdy = 1'b0;
        tick(1);
        chk("drain_count", rif.count, 0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
        tick(1);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_overrun"}, ovr, exp_ovr);
        chk({tag, "_frame_err"}, ferr, exp_ferr);
    endtask

    task automatic chk_reset();
        chk("rst_valid", rif.rd_valid, 0);
        chk("rst_data", rif.rd_data, 0);
        chk("rst_count", rif.count, 0);
        chk("rst_overrun", ovr, 0);
        chk("rst_frame_err", ferr, 0);
    endtask

    initial begin
        logic [9:0] fbits;
        int n;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk_reset();

        send(8'hA5, 1'b1, 1'b0);
        chk("a5_valid", rif.rd_valid, 1);
        chk("a5_data", rif.rd_data, 8'hA5);
        chk("a5_count", rif.count, 1);
        chk_flags("a5");
        drain();

        for (int i = 0; i <= DEPTH; i++) send(8'(i), 1'b1, 1'b0);
        chk("full_count", rif.count, DEPTH);
        chk("full_overrun", ovr, 1);
        chk_flags("full");
        drain();
        chk("drained_valid", rif.rd_valid, 0);
        chk("drained_data", rif.rd_data, 0);

        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b1, 1'b0);
        pulse_clr();
        chk("clr_overrun", ovr, 0);
        send(8'($urandom), 1'b1, 1'b1);
        chk("pushpop_count", rif.count, DEPTH);
        chk_flags("pushpop");
        drain();

        send(8'h3C, 1'b0, 1'b0);
        chk("ferr_count", rif.count, 0);
        chk_flags("ferr");
        pulse_clr();
        chk_flags("ferr_clr");
        send(8'h3C, 1'b1, 1'b0);
        chk("ferr_good_count", rif.count, 1);
        chk_flags("ferr_good");
        drain();

        pin = 1'b0;
        tick(4);
        pin = 1'b1;
        tick(30);
        chk("glitch_count", rif.count, 0);
        chk_flags("glitch");

        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b1, 1'b0);
        chk("pre_rst_count", rif.count, 3);
        fbits = {1'b1, 8'hFF, 1'b0};
        for (int k = 0; k < 4 * CPB; k++) begin
            pin = fbits[k / CPB];
            tick(1);
        end
        rst_n = 1'b0;
        pin = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk_reset();
        send(8'h81, 1'b1, 1'b0);
        chk("post_rst_count", rif.count, 1);
        chk("post_rst_data", rif.rd_data, 8'h81);
        drain();

        n = $urandom_range(4, 12);
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < n; i++)
                    send(8'($urandom), 1'b1, 1'b0);
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    rdy = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        rdy = 1'b0;
        drain();
        chk_flags("random");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/svc_soc_uart_rx.md
# svc_soc_uart_rx

UART receive peripheral for the RISC-V SoC: 8N1 deserializer plus a first-word-fall-through byte FIFO. It sits upstream of the I/O register bank and turns the board or simulator `urx_pin` line into bytes the CPU pops through the register bank's read path. It is the receive-side counterpart of the existing UART transmit path. In simulation it is driven by the terminal model's pin.

## Interface
- `CLOCK_FREQ`, 100_000_000: clk frequency in Hz.
- `BAUD_RATE`, 115_200: line rate. `CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE` (truncating); must be ≥ 4.
- `FIFO_DEPTH`, 16: byte entries; power of two, ≥ 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `urx_pin` in 1: asynchronous serial input, idle high.
- `rd_valid` out 1: FIFO non-empty.
- `rd_data` out 8: FIFO head byte; 8'h00 when empty.
- `rd_ready` in 1: pop request; pop occurs when `rd_valid && rd_ready`.
- `count` out `$clog2(FIFO_DEPTH)+1`: bytes held.
- `overrun` out 1: sticky; a byte was dropped because the FIFO was full.
- `frame_err` out 1: sticky; a stop bit was sampled low.
- `clr_err` in 1: clears `overrun` and `frame_err`.

## Operation
- Input path: 2-flop synchronizer on `urx_pin`, both flops reset to 1. The FSM sees only the synchronized bit `rx_s`.
- FSM states and transitions (bit counter `bit_cnt` 0..CLKS_PER_BIT-1, bit index 0..7):
  - IDLE: when `rx_s==0`, go to START and clear `bit_cnt`.
  - START: at `bit_cnt == CLKS_PER_BIT/2 - 1`, sample. If `rx_s==0`, go to DATA and clear `bit_cnt` and the index. If `rx_s==1`, treat as a glitch and return to IDLE with no error.
  - DATA: at `bit_cnt == CLKS_PER_BIT-1`, sample into the shift register LSB first. After index 7, go to STOP.
  - STOP: at `bit_cnt == CLKS_PER_BIT-1`, sample. If 1, push the byte. If 0, discard the byte and set `frame_err`. Return to IDLE in both cases.
- Push rules:
  - Push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise drop the byte and set `overrun`. FIFO contents are unchanged.
- Pop rules:
  - Pop on `rd_valid && rd_ready`.
  - `rd_ready` while empty is ignored.
  - Simultaneous push and pop leaves `count` unchanged.
- Errors: `clr_err` clears both flags. A set event in the same cycle as `clr_err` wins, so the flag stays 1.
- Line held low (break): each frame ends in `frame_err`. No byte is pushed. Reception resumes after the line returns high.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits wide and wrap modulo 2·FIFO_DEPTH. Full means the MSBs differ and the low bits are equal.

## Timing
- Reset values: `rd_valid` 0, `rd_data` 8'h00, `count` 0, `overrun` 0, `frame_err` 0. FSM in IDLE, synchronizer at 1.
- Reset mid-frame: the partial byte is discarded and the FIFO is emptied. If the line is low when reset releases, this is handled as a normal start-bit candidate.
- Latency: the push register updates on the clock after the stop-bit sample. `rd_valid` and `count` reflect the push on that edge. The stop sample occurs 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the start edge is registered by the first sync flop (±1 cycle of input phase).
- Read path: `rd_data` is combinational from the head entry (first-word fall-through). Pop takes effect at the clock edge, and the next head is visible in the following cycle.
- `overrun` and `frame_err` are registered and rise one cycle after the triggering sample.

## Structure
- Shared package `svc_soc_uart_pkg`: `uart_rx_state_t` enum (IDLE, START, DATA, STOP) and the `CLKS_PER_BIT` computation function.
- One sub-module, `svc_soc_uart_rx_fifo`: parameterized FWFT FIFO with push/pop/full/empty/count.
- The FSM, synchronizer and error flags live in the top module.

## Test plan
Bench settings: CLOCK_FREQ 1_843_200, BAUD_RATE 115_200, so CLKS_PER_BIT = 16.
- Send byte 8'hA5 with `rd_ready` = 0 → after the stop bit, `rd_valid` = 1, `rd_data` = 8'hA5, `count` = 1; no error flags.
- Send 17 bytes 8'h00..8'h10 with no pops → `count` = 16, `overrun` = 1; popping returns 8'h00..8'h0F in order, and the 17th byte is absent.
- With the FIFO full, send one byte while pulsing `rd_ready` in the push cycle → `count` stays 16 and `overrun` stays 0.
- Send 8'h3C with the stop bit driven 0 → no push, `frame_err` = 1. Then `clr_err` → both flags 0. Then send 8'h3C correctly → byte received.
- Drive a 4-cycle low glitch on an idle line → FSM returns to IDLE, no push, no flags.
- Assert `rst_n` low midway through the data bits of 8'hFF with 3 bytes queued → after reset, all outputs are at reset values and the next full frame of 8'h81 is received correctly.
